// File: rtl/write_back_stage_pkg.sv
// write_back_stage_pkg
//   Shared ISA definitions for the write-back slice: 4-bit major opcodes,
//   6-bit {opcode, cz} codes for the conditional arithmetic/logic group,
//   the write-data source selector and the zero-flag source selector.
//   Also used by the memory-stage store-forwarding logic.
//   No ports.
package write_back_stage_pkg;

  // Major opcodes, IR[15:12]
  localparam logic [3:0] OP_ADD_GRP = 4'b0000;  // ADD / ADC / ADZ
  localparam logic [3:0] OP_ADI     = 4'b0001;
  localparam logic [3:0] OP_NDU_GRP = 4'b0010;  // NDU / NDC / NDZ
  localparam logic [3:0] OP_LHI     = 4'b0011;
  localparam logic [3:0] OP_LW      = 4'b0100;
  localparam logic [3:0] OP_SW      = 4'b0101;
  localparam logic [3:0] OP_LM      = 4'b0110;
  localparam logic [3:0] OP_SM      = 4'b0111;
  localparam logic [3:0] OP_JAL     = 4'b1000;
  localparam logic [3:0] OP_JLR     = 4'b1001;
  localparam logic [3:0] OP_BEQ     = 4'b1100;

  // {opcode, cz} codes, cz = IR[1:0]
  localparam logic [5:0] FN_ADD = 6'b000000;
  localparam logic [5:0] FN_ADC = 6'b000010;
  localparam logic [5:0] FN_ADZ = 6'b000001;
  localparam logic [5:0] FN_NDU = 6'b001000;
  localparam logic [5:0] FN_NDC = 6'b001010;
  localparam logic [5:0] FN_NDZ = 6'b001001;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_MEM  = 2'd1,
    WB_SRC_LINK = 2'd2
  } wb_src_e;

  typedef enum logic {
    Z_SRC_ALU = 1'b0,
    Z_SRC_MEM = 1'b1
  } z_src_e;

  function automatic logic [5:0] op_cz(input logic [15:0] ir);
    return {ir[15:12], ir[1:0]};
  endfunction

endpackage

// File: rtl/write_back_stage_dest_decode.sv
// wb_dest_decode
//   Combinational decode of the MEM/WB instruction into register-file write
//   controls and flag-update controls. A cancelled instruction writes
//   nothing and touches no flag. Validity gating is done by the caller.
//   Ports:
//     ir_i          instruction word held in MEM/WB
//     cancel_i      1 = conditional op cancelled
//     lm_reg_sel_i  destination register for the current LM beat
//     we_o          write enable (before valid gating)
//     addr_o        destination register
//     src_o         write-data source
//     c_upd_o       carry flag takes the ALU carry
//     z_upd_o       zero flag is recomputed
//     z_src_o       zero flag computed from ALU result or memory data
module wb_dest_decode
  import write_back_stage_pkg::*;
#(
  parameter int RADDR_W = 3
) (
  input  logic [15:0]        ir_i,
  input  logic               cancel_i,
  input  logic [RADDR_W-1:0] lm_reg_sel_i,
  output logic               we_o,
  output logic [RADDR_W-1:0] addr_o,
  output wb_src_e            src_o,
  output logic               c_upd_o,
  output logic               z_upd_o,
  output z_src_e             z_src_o
);

  logic we_raw;
  logic c_raw;
  logic z_raw;

  // IR[2] carries no information for write-back.
  logic unused_ir_bit;
  assign unused_ir_bit = ir_i[2];

  always_comb begin
    we_raw  = 1'b0;
    c_raw   = 1'b0;
    z_raw   = 1'b0;
    addr_o  = ir_i[11:9];
    src_o   = WB_SRC_ALU;
    z_src_o = Z_SRC_ALU;
    case (ir_i[15:12])
      OP_ADD_GRP: begin
        addr_o = ir_i[5:3];
        if (op_cz(ir_i) == FN_ADD || op_cz(ir_i) == FN_ADC || op_cz(ir_i) == FN_ADZ) begin
          we_raw = 1'b1;
          c_raw  = 1'b1;
          z_raw  = 1'b1;
        end
      end
      OP_NDU_GRP: begin
        addr_o = ir_i[5:3];
        if (op_cz(ir_i) == FN_NDU || op_cz(ir_i) == FN_NDC || op_cz(ir_i) == FN_NDZ) begin
          we_raw = 1'b1;
          z_raw  = 1'b1;
        end
      end
      OP_ADI: begin
        addr_o = ir_i[8:6];
        we_raw = 1'b1;
        c_raw  = 1'b1;
        z_raw  = 1'b1;
      end
      OP_LHI: begin
        we_raw = 1'b1;
      end
      OP_LW: begin
        we_raw  = 1'b1;
        src_o   = WB_SRC_MEM;
        z_raw   = 1'b1;
        z_src_o = Z_SRC_MEM;
      end
      OP_LM: begin
        // Each LM beat names its own destination; flags are untouched.
        addr_o = lm_reg_sel_i;
        we_raw = 1'b1;
        src_o  = WB_SRC_MEM;
      end
      OP_JAL, OP_JLR: begin
        we_raw = 1'b1;
        src_o  = WB_SRC_LINK;
      end
      default: begin
        // SW, SM, BEQ and undefined encodings write nothing.
      end
    endcase
  end

  assign we_o    = we_raw & ~cancel_i;
  assign c_upd_o = c_raw  & ~cancel_i;
  assign z_upd_o = z_raw  & ~cancel_i;

endmodule

// File: rtl/write_back_stage.sv
// write_back_stage
//   MEM/WB pipeline register plus write-back: captures the memory-stage
//   result, drives the register-file write port and holds the architectural
//   carry/zero flags.
//   Optional feature macro: WB_R7_REDIRECT_EN -- when defined, a write to R7
//   raises pc_redirect with pc_target = write data in the same cycle; when
//   undefined both are tied to 0.
//   Ports:
//     clk, reset (sync, active-high), stall (hold MEM/WB), flush (bubble)
//     ex_mem_valid, IRfrompipe4, ALUOut, MemData, RAFromPipeInc,
//     ex_mem_carry, ex_mem_CCR_write, lm_reg_sel  -- EX/MEM inputs
//     IRfrompipe5, mem_wb_CCR_write, mem_wb_valid -- registered MEM/WB state
//     rf_write_en, rf_write_addr, rf_write_data  -- register-file write port
//     carry_flag, zero_flag                      -- architectural flags
//     pc_redirect, pc_target                     -- R7 redirect to fetch
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic               ex_mem_valid,
  input  logic [15:0]        IRfrompipe4,
  input  logic [DATA_W-1:0]  ALUOut,
  input  logic [DATA_W-1:0]  MemData,
  input  logic [DATA_W-1:0]  RAFromPipeInc,
  input  logic               ex_mem_carry,
  input  logic               ex_mem_CCR_write,
  input  logic [RADDR_W-1:0] lm_reg_sel,
  output logic [15:0]        IRfrompipe5,
  output logic               mem_wb_CCR_write,
  output logic               mem_wb_valid,
  output logic               rf_write_en,
  output logic [RADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0]  rf_write_data,
  output logic               carry_flag,
  output logic               zero_flag,
  output logic               pc_redirect,
  output logic [DATA_W-1:0]  pc_target
);

  // MEM/WB register
  logic [15:0]        ir_q,     ir_d;
  logic               valid_q,  valid_d;
  logic               cancel_q, cancel_d;
  logic [DATA_W-1:0]  alu_q,    alu_d;
  logic [DATA_W-1:0]  mem_q,    mem_d;
  logic [DATA_W-1:0]  link_q,   link_d;
  logic               carry_q,  carry_d;
  logic [RADDR_W-1:0] lm_sel_q, lm_sel_d;
  // Architectural flags
  logic               c_flag_q, c_flag_d;
  logic               z_flag_q, z_flag_d;

  logic               dec_we;
  logic [RADDR_W-1:0] dec_addr;
  wb_src_e            dec_src;
  logic               dec_c_upd;
  logic               dec_z_upd;
  z_src_e             dec_z_src;

  wb_dest_decode #(.RADDR_W(RADDR_W)) u_dest_decode (
    .ir_i         (ir_q),
    .cancel_i     (cancel_q),
    .lm_reg_sel_i (lm_sel_q),
    .we_o         (dec_we),
    .addr_o       (dec_addr),
    .src_o        (dec_src),
    .c_upd_o      (dec_c_upd),
    .z_upd_o      (dec_z_upd),
    .z_src_o      (dec_z_src)
  );

  // Capture: flush beats stall; stall holds everything.
  always_comb begin
    ir_d     = ir_q;
    valid_d  = valid_q;
    cancel_d = cancel_q;
    alu_d    = alu_q;
    mem_d    = mem_q;
    link_d   = link_q;
    carry_d  = carry_q;
    lm_sel_d = lm_sel_q;
    if (flush) begin
      ir_d     = '0;
      valid_d  = 1'b0;
      cancel_d = 1'b0;
    end else if (!stall) begin
      ir_d     = IRfrompipe4;
      valid_d  = ex_mem_valid;
      cancel_d = ex_mem_CCR_write;
      alu_d    = ALUOut;
      mem_d    = MemData;
      link_d   = RAFromPipeInc;
      carry_d  = ex_mem_carry;
      lm_sel_d = lm_reg_sel;
    end
  end

  // Flags retire with the instruction on the edge that ends its WB cycle.
  // While stalled the instruction is still in WB, so the update waits for
  // the non-stalled edge and happens exactly once.
  logic flag_upd;
  logic z_value;

  assign flag_upd = valid_q & ~stall;
  assign z_value  = (dec_z_src == Z_SRC_MEM) ? (mem_q == '0) : (alu_q == '0);

  always_comb begin
    c_flag_d = c_flag_q;
    z_flag_d = z_flag_q;
    if (flag_upd && dec_c_upd) c_flag_d = carry_q;
    if (flag_upd && dec_z_upd) z_flag_d = z_value;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q     <= '0;
      valid_q  <= 1'b0;
      cancel_q <= 1'b0;
      alu_q    <= '0;
      mem_q    <= '0;
      link_q   <= '0;
      carry_q  <= 1'b0;
      lm_sel_q <= '0;
      c_flag_q <= 1'b0;
      z_flag_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      valid_q  <= valid_d;
      cancel_q <= cancel_d;
      alu_q    <= alu_d;
      mem_q    <= mem_d;
      link_q   <= link_d;
      carry_q  <= carry_d;
      lm_sel_q <= lm_sel_d;
      c_flag_q <= c_flag_d;
      z_flag_q <= z_flag_d;
    end
  end

  // Write port
  always_comb begin
    case (dec_src)
      WB_SRC_MEM:  rf_write_data = mem_q;
      WB_SRC_LINK: rf_write_data = link_q;
      default:     rf_write_data = alu_q;
    endcase
  end

  assign rf_write_en      = valid_q & dec_we;
  assign rf_write_addr    = dec_addr;
  assign IRfrompipe5      = ir_q;
  assign mem_wb_valid     = valid_q;
  assign mem_wb_CCR_write = cancel_q;
  assign carry_flag       = c_flag_q;
  assign zero_flag        = z_flag_q;

`ifdef WB_R7_REDIRECT_EN
  assign pc_redirect = rf_write_en && (rf_write_addr == RADDR_W'(7));
  assign pc_target   = rf_write_data;
`else
  assign pc_redirect = 1'b0;
  assign pc_target   = '0;
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// tb_write_back_stage
//   Table of single-instruction vectors streamed back-to-back, with
//   expected outputs pushed to a queue when each vector is driven and
//   popped when the MEM/WB outputs appear one cycle later. Flag results
//   are checked one further cycle later, after the retiring edge.
//   Hand-written sequences cover stall, stall+flush and mid-stream reset.
module tb_write_back_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall, flush, ex_mem_valid;
  logic [15:0] IRfrompipe4, ALUOut, MemData, RAFromPipeInc;
  logic        ex_mem_carry, ex_mem_CCR_write;
  logic [2:0]  lm_reg_sel;
  logic [15:0] IRfrompipe5;
  logic        mem_wb_CCR_write, mem_wb_valid, rf_write_en;
  logic [2:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic        carry_flag, zero_flag, pc_redirect;
  logic [15:0] pc_target;

  write_back_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .ex_mem_valid     (ex_mem_valid),
    .IRfrompipe4      (IRfrompipe4),
    .ALUOut           (ALUOut),
    .MemData          (MemData),
    .RAFromPipeInc    (RAFromPipeInc),
    .ex_mem_carry     (ex_mem_carry),
    .ex_mem_CCR_write (ex_mem_CCR_write),
    .lm_reg_sel       (lm_reg_sel),
    .IRfrompipe5      (IRfrompipe5),
    .mem_wb_CCR_write (mem_wb_CCR_write),
    .mem_wb_valid     (mem_wb_valid),
    .rf_write_en      (rf_write_en),
    .rf_write_addr    (rf_write_addr),
    .rf_write_data    (rf_write_data),
    .carry_flag       (carry_flag),
    .zero_flag        (zero_flag),
    .pc_redirect      (pc_redirect),
    .pc_target        (pc_target)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int fails  = 0;

  // {we, addr, data, valid, ir, cancel, c, z}
  logic [39:0] exp_q[$];
  logic [1:0]  pend_flags;
  logic        pend_v = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        valid;
    logic [15:0] ir;
    logic [15:0] alu;
    logic [15:0] mem;
    logic [15:0] link;
    logic        carry;
    logic        cancel;
    logic [2:0]  lm;
    logic        exp_we;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic v, input logic [15:0] ir, input logic [15:0] alu,
                              input logic [15:0] mem, input logic [15:0] link,
                              input logic carry, input logic cancel, input logic [2:0] lm,
                              input logic we, input logic [2:0] addr, input logic [15:0] data,
                              input logic c, input logic z);
    vec_t r;
    r.valid = v; r.ir = ir; r.alu = alu; r.mem = mem; r.link = link;
    r.carry = carry; r.cancel = cancel; r.lm = lm;
    r.exp_we = we; r.exp_addr = addr; r.exp_data = data; r.exp_c = c; r.exp_z = z;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    stall = 1'b0; flush = 1'b0; ex_mem_valid = 1'b0;
    IRfrompipe4 = 16'h0; ALUOut = 16'h0; MemData = 16'h0; RAFromPipeInc = 16'h0;
    ex_mem_carry = 1'b0; ex_mem_CCR_write = 1'b0; lm_reg_sel = 3'd0;
  endtask

  task automatic drive_vec(input vec_t v);
    stall = 1'b0; flush = 1'b0;
    ex_mem_valid = v.valid; IRfrompipe4 = v.ir; ALUOut = v.alu; MemData = v.mem;
    RAFromPipeInc = v.link; ex_mem_carry = v.carry; ex_mem_CCR_write = v.cancel;
    lm_reg_sel = v.lm;
    exp_q.push_back({v.exp_we, v.exp_addr, v.exp_data, v.valid, v.ir, v.cancel,
                     v.exp_c, v.exp_z});
  endtask

  task automatic chk_redirect(input logic we, input logic [2:0] addr, input logic [15:0] data);
`ifdef WB_R7_REDIRECT_EN
    chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, we && (addr == 3'd7)});
    if (we && addr == 3'd7) chk("pc_target", {16'd0, pc_target}, {16'd0, data});
`else
    chk("pc_redirect", {31'd0, pc_redirect}, 32'd0);
    chk("pc_target", {16'd0, pc_target}, 32'd0);
`endif
  endtask

  // One clock; sample #1 after the edge; retire flag and output expectations.
  task automatic step();
    logic [39:0] e;
    @(posedge clk);
    #1;
    if (pend_v) begin
      chk("carry_flag", {31'd0, carry_flag}, {31'd0, pend_flags[1]});
      chk("zero_flag",  {31'd0, zero_flag},  {31'd0, pend_flags[0]});
      pend_v = 1'b0;
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rf_write_en",      {31'd0, rf_write_en},      {31'd0, e[39]});
      chk("mem_wb_valid",     {31'd0, mem_wb_valid},     {31'd0, e[19]});
      chk("IRfrompipe5",      {16'd0, IRfrompipe5},      {16'd0, e[18:3]});
      chk("mem_wb_CCR_write", {31'd0, mem_wb_CCR_write}, {31'd0, e[2]});
      if (e[39]) begin
        chk("rf_write_addr", {29'd0, rf_write_addr}, {29'd0, e[38:36]});
        chk("rf_write_data", {16'd0, rf_write_data}, {16'd0, e[35:20]});
      end
      chk_redirect(e[39], e[38:36], e[35:20]);
      pend_flags = e[1:0];
      pend_v     = 1'b1;
    end
  endtask

  // ---------------- test ----------------
  initial begin
    //              v  ir       alu      mem      link     cy ca lm  we a  data     C Z
    vecs[0]  = mk(1, 16'h0298, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 3, 16'h0000, 1, 1); // ADD R3
    vecs[1]  = mk(1, 16'h4840, 16'h0000, 16'h00A5, 16'h0000, 0, 0, 0, 1, 4, 16'h00A5, 1, 0); // LW R4
    vecs[2]  = mk(1, 16'h02AA, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0, 0, 0, 16'h0000, 1, 0); // ADC cancelled
    vecs[3]  = mk(1, 16'h8E05, 16'h0000, 16'h0000, 16'h0011, 0, 0, 0, 1, 7, 16'h0011, 1, 0); // JAL R7
    vecs[4]  = mk(1, 16'h22B0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 6, 16'h0000, 1, 1); // NDU R6
    vecs[5]  = mk(1, 16'h1343, 16'h8001, 16'h0000, 16'h0000, 0, 0, 0, 1, 5, 16'h8001, 0, 0); // ADI R5
    vecs[6]  = mk(1, 16'h54C1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0); // SW
    vecs[7]  = mk(1, 16'h340F, 16'h0780, 16'h0000, 16'h0000, 0, 0, 0, 1, 2, 16'h0780, 0, 0); // LHI R2
    vecs[8]  = mk(1, 16'h6281, 16'h0000, 16'h0000, 16'h0000, 0, 0, 6, 1, 6, 16'h0000, 0, 0); // LM beat R6
    vecs[9]  = mk(1, 16'hC282, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0, 0); // BEQ
    vecs[10] = mk(1, 16'h0709, 16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, 16'hFFFF, 1, 0); // ADZ R1
    vecs[11] = mk(1, 16'h2711, 16'h0000, 16'h1234, 16'h0000, 0, 0, 0, 1, 2, 16'h0000, 1, 1); // NDZ R2
    vecs[12] = mk(1, 16'h90C0, 16'h0000, 16'h0000, 16'h0042, 0, 0, 0, 1, 0, 16'h0042, 1, 1); // JLR R0
    vecs[13] = mk(0, 16'h0298, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 1, 1); // not valid

    // Reset state
    reset = 1'b1;
    drive_idle();
    IRfrompipe4 = 16'($urandom_range(0, 16'hFFFF));
    ex_mem_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset IRfrompipe5",  {16'd0, IRfrompipe5},      32'd0);
    chk("reset mem_wb_valid", {31'd0, mem_wb_valid},     32'd0);
    chk("reset CCR_write",    {31'd0, mem_wb_CCR_write}, 32'd0);
    chk("reset rf_write_en",  {31'd0, rf_write_en},      32'd0);
    chk("reset carry_flag",   {31'd0, carry_flag},       32'd0);
    chk("reset zero_flag",    {31'd0, zero_flag},        32'd0);
    chk("reset pc_redirect",  {31'd0, pc_redirect},      32'd0);
    reset = 1'b0;
    drive_idle();

    // Table vectors, back-to-back
    for (int i = 0; i < NV; i++) begin
      drive_vec(vecs[i]);
      step();
    end
    drive_idle();
    step();
    chk("queue drained", exp_q.size(), 32'd0);
    // Flags now C=1, Z=1

    // Stall with a valid ADD: write stays asserted, flags retire once.
    drive_idle();
    ex_mem_valid = 1'b1; IRfrompipe4 = 16'h0298; ALUOut = 16'h0005; ex_mem_carry = 1'b0;
    @(posedge clk); #1;
    stall = 1'b1; ex_mem_valid = 1'b0; ALUOut = 16'hFFFF; IRfrompipe4 = 16'h4840;
    @(posedge clk); #1;
    chk("stall rf_write_en",   {31'd0, rf_write_en},   32'd1);
    chk("stall rf_write_addr", {29'd0, rf_write_addr}, 32'd3);
    chk("stall rf_write_data", {16'd0, rf_write_data}, 32'h0005);
    chk("stall IRfrompipe5",   {16'd0, IRfrompipe5},   32'h0298);
    chk("stall carry held",    {31'd0, carry_flag},    32'd1);
    chk("stall zero held",     {31'd0, zero_flag},     32'd1);
    stall = 1'b0;
    @(posedge clk); #1;
    chk("post-stall carry",    {31'd0, carry_flag},    32'd0);
    chk("post-stall zero",     {31'd0, zero_flag},     32'd0);
    chk("post-stall valid",    {31'd0, mem_wb_valid},  32'd0);
    chk("post-stall write_en", {31'd0, rf_write_en},   32'd0);

    // Stall and flush together with a valid ADD: bubble.
    drive_idle();
    ex_mem_valid = 1'b1; IRfrompipe4 = 16'h0298; ALUOut = 16'h0000; ex_mem_carry = 1'b1;
    stall = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush mem_wb_valid", {31'd0, mem_wb_valid}, 32'd0);
    chk("flush IRfrompipe5",  {16'd0, IRfrompipe5},  32'd0);
    chk("flush rf_write_en",  {31'd0, rf_write_en},  32'd0);
    drive_idle();
    @(posedge clk); #1;
    chk("flush carry kept",   {31'd0, carry_flag},   32'd0);
    chk("flush zero kept",    {31'd0, zero_flag},    32'd0);

    // NDU sets Z=1, then reset mid-stream clears everything.
    drive_idle();
    ex_mem_valid = 1'b1; IRfrompipe4 = 16'h22B0; ALUOut = 16'h0000;
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    chk("ndu zero set", {31'd0, zero_flag}, 32'd1);
    ex_mem_valid = 1'b1; IRfrompipe4 = 16'h22B0; ALUOut = 16'h0000;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid reset zero",     {31'd0, zero_flag},    32'd0);
    chk("mid reset carry",    {31'd0, carry_flag},   32'd0);
    chk("mid reset valid",    {31'd0, mem_wb_valid}, 32'd0);
    chk("mid reset write_en", {31'd0, rf_write_en},  32'd0);
    chk("mid reset IR",       {16'd0, IRfrompipe5},  32'd0);
    reset = 1'b0;
    drive_idle();
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
